// File: rtl/cam_pkg.sv
// Shared types and defaults for the Pass-Keeper CAM storage/compare stage.
// Optional ternary matching is enabled by defining CAM_TERNARY_EN.
package cam_pkg;

   typedef enum logic {
      CAM_IDLE,
      CAM_CLEAR
   } cam_state_e;

   localparam int unsigned CAM_DEPTH_DEF     = 4;
   localparam int unsigned CAM_KEY_WIDTH_DEF = 32;

   // Entry index width; never narrower than one bit.
   function automatic int unsigned cam_addr_w(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/cam_entry.sv
// One CAM entry: key, valid bit and (with CAM_TERNARY_EN) a don't-care mask,
// plus the combinational match against the current search key.
module cam_entry #(
   parameter int unsigned KEY_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_stb,
   input  logic                 del_stb,
   input  logic                 clr_stb,
   input  logic [KEY_WIDTH-1:0] wr_key,
`ifdef CAM_TERNARY_EN
   input  logic [KEY_WIDTH-1:0] wr_mask,
`endif
   input  logic [KEY_WIDTH-1:0] search_key,
   output logic                 match_c
);

   logic                 valid_q, valid_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [KEY_WIDTH-1:0] care_c;

   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      if (wr_stb) begin
         valid_d = 1'b1;
         key_d   = wr_key;
      end
      if (del_stb || clr_stb) valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= valid_d;
   end

   // Key storage is intentionally not reset; valid gates every use of it.
   always_ff @(posedge clk) begin
      key_q <= key_d;
   end

`ifdef CAM_TERNARY_EN
   logic [KEY_WIDTH-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if (wr_stb) mask_d = wr_mask;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) mask_q <= '0;
      else        mask_q <= mask_d;
   end

   assign care_c = ~mask_q;
`else
   assign care_c = '1;
`endif

   assign match_c = valid_q && (((key_q ^ search_key) & care_c) == '0);

endmodule

// File: rtl/cam_match_array.sv
// CAM storage and parallel compare; registered match vector feeds the encoder.
// Define CAM_TERNARY_EN to add a per-entry don't-care mask (wr_mask port).
module cam_match_array
   import cam_pkg::*;
#(
   parameter  int unsigned DEPTH     = CAM_DEPTH_DEF,
   parameter  int unsigned KEY_WIDTH = CAM_KEY_WIDTH_DEF,
   localparam int unsigned ADDR_W    = cam_addr_w(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic                 wr_del,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [KEY_WIDTH-1:0] wr_key,
`ifdef CAM_TERNARY_EN
   input  logic [KEY_WIDTH-1:0] wr_mask,
`endif
   output logic                 wr_ready,
   input  logic                 clr_start,
   output logic                 busy,
   input  logic                 search_valid,
   input  logic [KEY_WIDTH-1:0] search_key,
   output logic                 search_ready,
   output logic                 match_valid,
   output logic [DEPTH-1:0]     match_lines,
   output logic                 match_any
);

   cam_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                rdy_q, rdy_d;
   logic                match_valid_q, match_valid_d;
   logic [DEPTH-1:0]    match_lines_q, match_lines_d;
   logic                match_any_q, match_any_d;

   logic                wr_acc_c, srch_acc_c;
   logic [DEPTH-1:0]    wr_stb_c, del_stb_c, clr_stb_c, match_c;

   assign wr_acc_c   = wr_en & rdy_q;
   assign srch_acc_c = search_valid & rdy_q;

   // Per-entry strobes; addresses beyond DEPTH-1 decode to nothing.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wr_stb_c[i]  = wr_acc_c & ~wr_del & (wr_addr == ADDR_W'(i));
         del_stb_c[i] = wr_acc_c &  wr_del & (wr_addr == ADDR_W'(i));
         clr_stb_c[i] = (state_q == CAM_CLEAR) && (cnt_q == ADDR_W'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      cam_entry #(
         .KEY_WIDTH (KEY_WIDTH)
      ) u_entry (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_stb     (wr_stb_c[g]),
         .del_stb    (del_stb_c[g]),
         .clr_stb    (clr_stb_c[g]),
         .wr_key     (wr_key),
`ifdef CAM_TERNARY_EN
         .wr_mask    (wr_mask),
`endif
         .search_key (search_key),
         .match_c    (match_c[g])
      );
   end

   // Next state, sweep counter, handshake flags and match register.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      match_valid_d = srch_acc_c;
      match_lines_d = match_lines_q;
      match_any_d   = match_any_q;

      case (state_q)
         CAM_IDLE: begin
            if (clr_start) begin
               state_d = CAM_CLEAR;
               cnt_d   = '0;
            end
         end
         CAM_CLEAR: begin
            cnt_d = ADDR_W'(cnt_q + 1'b1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = CAM_IDLE;
         end
         default: state_d = CAM_IDLE;
      endcase

      busy_d = (state_d == CAM_CLEAR);
      rdy_d  = (state_d == CAM_IDLE);

      if (srch_acc_c) begin
         match_lines_d = match_c;
         match_any_d   = |match_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= CAM_IDLE;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         rdy_q         <= 1'b1;
         match_valid_q <= 1'b0;
         match_lines_q <= '0;
         match_any_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         rdy_q         <= rdy_d;
         match_valid_q <= match_valid_d;
         match_lines_q <= match_lines_d;
         match_any_q   <= match_any_d;
      end
   end

   assign busy         = busy_q;
   assign wr_ready     = rdy_q;
   assign search_ready = rdy_q;
   assign match_valid  = match_valid_q;
   assign match_lines  = match_lines_q;
   assign match_any    = match_any_q;

endmodule

// File: tb/tb_cam_match_array.sv
// Directed self-checking bench for cam_match_array (DEPTH=4, KEY_WIDTH=32).
module tb_cam_match_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, wr_del;
   logic [1:0]  wr_addr;
   logic [31:0] wr_key;
   logic [31:0] wr_mask;
   logic        wr_ready, clr_start, busy;
   logic        search_valid, search_ready;
   logic [31:0] search_key;
   logic        match_valid, match_any;
   logic [3:0]  match_lines;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cam_match_array #(.DEPTH(4), .KEY_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_del       (wr_del),
      .wr_addr      (wr_addr),
      .wr_key       (wr_key),
`ifdef CAM_TERNARY_EN
      .wr_mask      (wr_mask),
`endif
      .wr_ready     (wr_ready),
      .clr_start    (clr_start),
      .busy         (busy),
      .search_valid (search_valid),
      .search_key   (search_key),
      .search_ready (search_ready),
      .match_valid  (match_valid),
      .match_lines  (match_lines),
      .match_any    (match_any)
   );

   // Advance one rising edge and settle just after it.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] k);
      wr_en = 1'b1; wr_del = 1'b0; wr_addr = a; wr_key = k;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic do_delete(input logic [1:0] a);
      wr_en = 1'b1; wr_del = 1'b1; wr_addr = a;
      cycle();
      wr_en = 1'b0; wr_del = 1'b0;
   endtask

   task automatic do_search(input logic [31:0] k);
      search_valid = 1'b1; search_key = k;
      cycle();
      search_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycle(); cycle();
      rst_n = 1'b1;
      checks++; if (match_valid !== 1'b0) begin errors++; $display("FAIL reset_match_valid: got %b want 0", match_valid); end
      checks++; if (match_lines !== 4'b0000) begin errors++; $display("FAIL reset_match_lines: got %b want 0000", match_lines); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({wr_ready, search_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b want 11", {wr_ready, search_ready}); end
   endtask

   task automatic test_empty_search();
      do_search(32'hDEADBEEF);
      checks++; if (match_valid !== 1'b1) begin errors++; $display("FAIL empty_valid: got %b want 1", match_valid); end
      checks++; if ({match_lines, match_any} !== 5'b0000_0) begin errors++; $display("FAIL empty_lines: got %b/%b want 0000/0", match_lines, match_any); end
      cycle();
      checks++; if (match_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b want 0", match_valid); end
   endtask

   task automatic test_single_write();
      do_write(2'd2, 32'hDEADBEEF);
      do_search(32'hDEADBEEF);
      checks++; if ({match_valid, match_lines, match_any} !== 6'b1_0100_1) begin errors++; $display("FAIL single_hit: got %b want 1_0100_1", {match_valid, match_lines, match_any}); end
      cycle();
      checks++; if ({match_valid, match_lines} !== 5'b0_0100) begin errors++; $display("FAIL lines_hold: got %b want 0_0100", {match_valid, match_lines}); end
   endtask

   task automatic test_multi_delete();
      do_write(2'd1, 32'h1234);
      do_write(2'd3, 32'h1234);
      do_search(32'h1234);
      checks++; if (match_lines !== 4'b1010) begin errors++; $display("FAIL multi_hit: got %b want 1010", match_lines); end
      do_delete(2'd3);
      do_search(32'h1234);
      checks++; if (match_lines !== 4'b0010) begin errors++; $display("FAIL after_delete: got %b want 0010", match_lines); end
   endtask

   task automatic test_read_before_write();
      wr_en = 1'b1; wr_del = 1'b0; wr_addr = 2'd0; wr_key = 32'hAA;
      search_valid = 1'b1; search_key = 32'hAA;
      cycle();
      wr_en = 1'b0; search_valid = 1'b0;
      checks++; if ({match_valid, match_lines} !== 5'b1_0000) begin errors++; $display("FAIL rbw_same_cycle: got %b want 1_0000", {match_valid, match_lines}); end
      do_search(32'hAA);
      checks++; if (match_lines !== 4'b0001) begin errors++; $display("FAIL rbw_next: got %b want 0001", match_lines); end
   endtask

   // Entries now: 0=AA, 1=1234, 2=DEADBEEF, 3 invalid.
   task automatic test_back_to_back();
      search_valid = 1'b1; search_key = 32'hAA;
      cycle();
      checks++; if ({match_valid, match_lines} !== 5'b1_0001) begin errors++; $display("FAIL b2b_0: got %b want 1_0001", {match_valid, match_lines}); end
      search_key = 32'h1234;
      cycle();
      checks++; if ({match_valid, match_lines} !== 5'b1_0010) begin errors++; $display("FAIL b2b_1: got %b want 1_0010", {match_valid, match_lines}); end
      search_key = 32'hDEADBEEF;
      cycle();
      checks++; if ({match_valid, match_lines} !== 5'b1_0100) begin errors++; $display("FAIL b2b_2: got %b want 1_0100", {match_valid, match_lines}); end
      search_key = 32'h5555_5555;
      cycle();
      search_valid = 1'b0;
      checks++; if ({match_valid, match_lines, match_any} !== 6'b1_0000_0) begin errors++; $display("FAIL b2b_miss: got %b want 1_0000_0", {match_valid, match_lines, match_any}); end
      do_write(2'd0, 32'h1234);
      do_search(32'h1234);
      checks++; if (match_lines !== 4'b0011) begin errors++; $display("FAIL duplicate: got %b want 0011", match_lines); end
   endtask

   task automatic test_clear();
      int n;
      for (int i = 0; i < 4; i++) do_write(2'(i), 32'h10 + 32'(i));
      clr_start = 1'b1;
      cycle();
      clr_start = 1'b0;
      wr_en = 1'b1; wr_del = 1'b0; wr_addr = 2'd1; wr_key = 32'h55;
      search_valid = 1'b1; search_key = 32'h10;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         checks++; if ({wr_ready, search_ready, match_valid} !== 3'b000) begin errors++; $display("FAIL clear_blocked: got %b want 000 at busy cycle %0d", {wr_ready, search_ready, match_valid}, n); end
         n++;
         cycle();
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL clear_len: got %0d busy cycles want 4", n); end
      checks++; if ({wr_ready, search_ready} !== 2'b11) begin errors++; $display("FAIL clear_ready_back: got %b want 11", {wr_ready, search_ready}); end
      cycle();
      wr_en = 1'b0; search_valid = 1'b0;
      checks++; if ({match_valid, match_lines} !== 5'b1_0000) begin errors++; $display("FAIL clear_held_search: got %b want 1_0000", {match_valid, match_lines}); end
      do_search(32'h55);
      checks++; if (match_lines !== 4'b0010) begin errors++; $display("FAIL clear_held_write: got %b want 0010", match_lines); end
      do_search(32'h13);
      checks++; if (match_lines !== 4'b0000) begin errors++; $display("FAIL clear_entry3: got %b want 0000", match_lines); end
   endtask

   task automatic test_reset_mid_clear();
      do_write(2'd3, 32'h77);
      clr_start = 1'b1;
      cycle();
      clr_start = 1'b0;
      cycle();
      rst_n = 1'b0;
      search_valid = 1'b1; search_key = 32'h77;
      cycle();
      rst_n = 1'b1; search_valid = 1'b0;
      checks++; if ({busy, wr_ready, search_ready, match_valid} !== 4'b0110) begin errors++; $display("FAIL mid_clear_reset: got %b want 0110", {busy, wr_ready, search_ready, match_valid}); end
      do_search(32'h77);
      checks++; if (match_lines !== 4'b0000) begin errors++; $display("FAIL reset_invalidates: got %b want 0000", match_lines); end
   endtask

`ifdef CAM_TERNARY_EN
   task automatic test_ternary();
      wr_mask = 32'h0000FFFF;
      do_write(2'd1, 32'h12340000);
      wr_mask = 32'h0;
      do_search(32'h1234ABCD);
      checks++; if (match_lines !== 4'b0010) begin errors++; $display("FAIL ternary_hit: got %b want 0010", match_lines); end
      do_search(32'h1235ABCD);
      checks++; if (match_lines !== 4'b0000) begin errors++; $display("FAIL ternary_miss: got %b want 0000", match_lines); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_del = 1'b0; wr_addr = '0; wr_key = '0;
      wr_mask = '0; clr_start = 1'b0; search_valid = 1'b0; search_key = '0;
      test_reset();
      test_empty_search();
      test_single_write();
      test_multi_delete();
      test_read_before_write();
      test_back_to_back();
      test_clear();
      test_reset_mid_clear();
`ifdef CAM_TERNARY_EN
      test_ternary();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cam_match_array.md
Name: cam_match_array

Overview:
- Storage and compare stage of the Pass-Keeper CAM. Sits directly upstream of the priority encoder.
- Holds DEPTH keys, each with a valid bit. On a search it compares the key against every valid entry in parallel and presents a registered one-hot/multi-hot match vector.
- The match vector drives the encoder's input_unencoded bus one cycle after the search is accepted.
- Also provides entry write/delete and a multi-cycle clear-all sweep.

Parameters:
- DEPTH, 4: number of entries. Must be even and ≥2 (downstream encoder pairs lines).
- KEY_WIDTH, 32: bits per stored key.
- ADDR_W, $clog2(DEPTH): entry index width. Derived; do not override.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write/delete request, accepted when wr_ready=1
- wr_del  in  1  with wr_en: 1 = invalidate entry, 0 = store key
- wr_addr  in  ADDR_W  target entry
- wr_key  in  KEY_WIDTH  key to store
- wr_ready  out  1  write port can accept
- clr_start  in  1  pulse: invalidate all entries
- busy  out  1  clear sweep in progress
- search_valid  in  1  search request, accepted when search_ready=1
- search_key  in  KEY_WIDTH  key to look up
- search_ready  out  1  search port can accept
- match_valid  out  1  match_lines valid this cycle (1-cycle pulse per accepted search)
- match_lines  out  DEPTH  bit i = entry i valid and equal to search_key; feeds encoder input_unencoded
- match_any  out  1  OR of match_lines, registered with it

Behaviour:
- Reset (rst_n=0 at posedge):
  - All valid bits cleared; key storage not reset.
  - FSM goes to IDLE.
  - match_valid=0, match_lines=0, match_any=0, busy=0.
  - wr_ready=1 and search_ready=1 from the first cycle after reset.
  - Reset mid-sweep or mid-search aborts immediately.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR: clr_start=1.
  - CLEAR: a counter runs 0..DEPTH-1 and clears valid[cnt] once per cycle. Exits to IDLE after clearing entry DEPTH-1. The sweep takes exactly DEPTH cycles.
  - In CLEAR: busy=1, wr_ready=0, search_ready=0. clr_start is ignored.
- Write, IDLE only, on wr_en & wr_ready:
  - wr_del=0: key[wr_addr] <= wr_key and valid[wr_addr] <= 1.
  - wr_del=1: valid[wr_addr] <= 0.
  - Takes effect at that posedge.
- Search, on search_valid & search_ready:
  - Compare is combinational against current contents.
  - Result is registered, so match_valid=1 in the next cycle.
  - Latency is 1 cycle; throughput is one search per cycle.
  - With no accepted search, match_valid=0 and match_lines holds its last value.
- Simultaneous write and search in the same cycle: the search sees pre-write contents (read-before-write). The write still completes.
- Simultaneous clr_start and write/search in IDLE:
  - The write and search are accepted that cycle.
  - CLEAR starts next cycle.
  - The entry-0 clear takes precedence over any later write (none accepted in CLEAR).
- Duplicate keys: multiple bits may be set in match_lines. The downstream encoder resolves them; this block does not prioritise.
- An out-of-range wr_addr (non-power-of-2 DEPTH) is ignored.

Optional Feature:
- Macro: CAM_TERNARY_EN.
- Defined:
  - Adds input wr_mask[KEY_WIDTH-1:0], stored per entry with the key.
  - Mask bit 1 = don't-care. Entry i matches when ((key[i] ^ search_key) & ~mask[i]) == 0.
  - Masks are reset to 0.
- Undefined:
  - No wr_mask port and no mask storage.
  - Exact equality compare only.

Decomposition:
- Package cam_pkg:
  - FSM state enum (CAM_IDLE, CAM_CLEAR).
  - Default KEY_WIDTH and DEPTH localparams.
  - A function giving ADDR_W from DEPTH.
- Sub-module cam_entry, one per entry, instanced in a generate loop:
  - Holds key, valid and optional mask.
  - Takes write strobe, delete strobe and clear strobe.
  - Outputs a combinational match bit.
- Top-level owns the FSM, sweep counter, handshakes and the output register.

Test Plan:
1. Reset, then search 0xDEADBEEF → next cycle match_valid=1, match_lines=0000, match_any=0.
2. Write 0xDEADBEEF to entry 2, then search 0xDEADBEEF → next cycle match_lines=0100, match_any=1; encoder downstream yields 2.
3. Write 0x1234 to entries 1 and 3, search 0x1234 → match_lines=1010. Delete entry 3, search again → 0010.
4. In the same cycle write 0xAA to entry 0 and search 0xAA → match_lines=0000. Search 0xAA next cycle → 0001.
5. Fill all 4 entries, pulse clr_start → busy=1 and ready=0 for exactly 4 cycles. Any search after that returns 0000. Search and write requests held during busy are not accepted until ready returns.
6. Assert rst_n=0 during cycle 2 of a clear → next cycle busy=0, both readys=1, match_valid=0. With CAM_TERNARY_EN: store 0x12340000 with mask 0x0000FFFF at entry 1, search 0x1234ABCD → match_lines=0010.
